execute_stage_pipe: RTL and testbench
=====================================

// Module: execute_stage_pipe
// PURPOSE
//  Parametrised RV32-class execute stage plus EX/MEM pipeline register. Operand forwarding,
//  full branch-condition set, jumps, downstream stall/bubble control, optional multi-cycle
//  iterative multiplier. Sits between the decode/ID-EX register and the memory stage.
// PARAMETERS
//  XLEN       32  datapath width (operands, PCs, results)
//  REG_AW     5   register-address width
//  ALUCTRL_W  4   ALU operation code width
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         synchronous reset, active low
//  valid_e       in   1         E slot holds a real instruction
//  flush_e       in   1         kill E instruction (no writeback, no redirect, aborts multiply)
//  stall_m       in   1         hold EX/MEM register contents
//  reg_write_e / mem_write_e / result_src_e  in  1  control, passed to M
//  alu_src_e     in   1         0: SrcB = forwarded rs2; 1: SrcB = imm_ext_e
//  alu_ctrl_e    in   ALUCTRL_W operation code, see BEHAVIOUR
//  branch_e      in   1         conditional branch
//  jump_e        in   1         unconditional jump, target = pc_e + imm_ext_e
//  br_type_e     in   3         funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
//  fwd_a_e, fwd_b_e  in  2      00 regfile, 01 result_w, 10 alu_result_m, 11 regfile
//  rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w  in  XLEN
//  rd_e          in   REG_AW    destination register
//  pcsrc_e       out  1         redirect fetch
//  pc_target_e   out  XLEN      pc_e + imm_ext_e, modulo 2^XLEN
//  stall_e       out  1         E busy; upstream must hold
//  valid_m, reg_write_m, mem_write_m, result_src_m  out 1   registered
//  rd_m          out  REG_AW    registered
//  alu_result_m, write_data_m, pc_plus4_m  out  XLEN  registered (write_data_m = forwarded rs2)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): all registered outputs 0, multiplier FSM IDLE. Reset overrides everything.
//  - ALU ops: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, A mul; others -> 0.
//    Add/sub wrap modulo 2^XLEN; shift amount = SrcB[$clog2(XLEN)-1:0]; slt/sltu produce 0/1.
//  - Branch cond on forwarded operands A, B (before SrcB mux); undefined br_type -> not taken.
//  - pcsrc_e = valid_e & ~flush_e & (jump_e | (branch_e & cond)); combinational; held while stalled.
//  - EX/MEM register update priority per posedge: reset > stall_m (hold all) > bubble > capture.
//    Bubble (valid_m=0, reg_write_m=0, mem_write_m=0, data fields don't-care) when flush_e,
//    ~valid_e, or stall_e. Capture otherwise; single-cycle ops have 1-cycle E->M latency.
//  - Multiplier FSM IDLE/BUSY/DONE (only with EXEC_MUL_EN):
//    IDLE: valid_e & ~flush_e & op=A -> latch A,B, cnt=XLEN, go BUSY; stall_e=1 this cycle.
//    BUSY: one shift-add step per cycle, cnt-1; stall_e=1; cnt reaches 0 -> DONE.
//    DONE: stall_e=0, product low XLEN bits presented; leave to IDLE on the edge the EX/MEM
//      register captures (~stall_m); stay DONE while stall_m=1.
//    flush_e in BUSY or DONE -> IDLE next edge, result discarded, stall_e=0 in flush cycle.
//    Operands latched at start; later forwarding changes ignored. stall_e high for XLEN+1 cycles.
//  - stall_e never depends on stall_m (no combinational loop with hazard unit).
// CONFIGURATION
//  EXEC_MUL_EN defined: multiplier FSM present, op A = mul low word, behaviour as above.
//  EXEC_MUL_EN undefined: no FSM, stall_e tied 0, op A yields 0 in one cycle like undefined ops.
// TESTING
//  1 add x5: rd1=7, rd2=5, fwd 00/00, alu_src=0 -> next edge alu_result_m=12, rd_m=5, valid_m=1.
//  2 Forward: fwd_a=10, alu_result_m=0xFFFFFFFF, rd2=1, op add -> alu_result_m=0 (wrap).
//  3 Branch: blt, A=-1, B=1, pc_e=0x100, imm=0x20 -> pcsrc_e=1, pc_target_e=0x120; bltu -> pcsrc_e=0.
//  4 stall_m=1 for 3 cycles with new E ops -> M outputs unchanged; released -> next op captured.
//  5 EXEC_MUL_EN, XLEN=32: mul 3*0xFFFFFFFF -> stall_e high 33 cycles, then alu_result_m=0xFFFFFFFD.
//  6 flush_e at BUSY cycle 10 -> stall_e=0, valid_m=0 next edge; new add completes in 1 cycle;
//    rst=0 mid-mul -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/execute_stage_pipe.sv
// RV32-class execute stage with operand forwarding, branch/jump resolution and EX/MEM register.
// Optional iterative shift-add multiplier for ALU op 0xA, enabled by defining EXEC_MUL_EN.
module execute_stage_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_e,
  input  logic                 flush_e,
  input  logic                 stall_m,
  input  logic                 reg_write_e,
  input  logic                 mem_write_e,
  input  logic                 result_src_e,
  input  logic                 alu_src_e,
  input  logic [ALUCTRL_W-1:0] alu_ctrl_e,
  input  logic                 branch_e,
  input  logic                 jump_e,
  input  logic [2:0]           br_type_e,
  input  logic [1:0]           fwd_a_e,
  input  logic [1:0]           fwd_b_e,
  input  logic [XLEN-1:0]      rd1_e,
  input  logic [XLEN-1:0]      rd2_e,
  input  logic [XLEN-1:0]      imm_ext_e,
  input  logic [XLEN-1:0]      pc_e,
  input  logic [XLEN-1:0]      pc_plus4_e,
  input  logic [XLEN-1:0]      result_w,
  input  logic [REG_AW-1:0]    rd_e,
  output logic                 pcsrc_e,
  output logic [XLEN-1:0]      pc_target_e,
  output logic                 stall_e,
  output logic                 valid_m,
  output logic                 reg_write_m,
  output logic                 mem_write_m,
  output logic                 result_src_m,
  output logic [REG_AW-1:0]    rd_m,
  output logic [XLEN-1:0]      alu_result_m,
  output logic [XLEN-1:0]      write_data_m,
  output logic [XLEN-1:0]      pc_plus4_m
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [ALUCTRL_W-1:0] OP_ADD  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] OP_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] OP_AND  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] OP_OR   = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] OP_XOR  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] OP_SLT  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] OP_SLTU = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] OP_SLL  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] OP_SRL  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] OP_SRA  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] OP_MUL  = ALUCTRL_W'(10);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_mul_result;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_cond;
  logic            w_stall;

  // Operand forwarding: 01 writeback, 10 memory stage, else register file
  always_comb begin
    w_src_a = rd1_e;
    w_fwd_b = rd2_e;
    if (fwd_a_e == 2'b01)      w_src_a = result_w;
    else if (fwd_a_e == 2'b10) w_src_a = alu_result_m;
    if (fwd_b_e == 2'b01)      w_fwd_b = result_w;
    else if (fwd_b_e == 2'b10) w_fwd_b = alu_result_m;
  end

  assign w_src_b = alu_src_e ? imm_ext_e : w_fwd_b;
  assign w_shamt = w_src_b[SHW-1:0];
  assign w_lt_s  = $signed(w_src_a) < $signed(w_src_b);
  assign w_lt_u  = w_src_a < w_src_b;

  always_comb begin
    w_alu_result = '0;
    case (alu_ctrl_e)
      OP_ADD:  w_alu_result = w_src_a + w_src_b;
      OP_SUB:  w_alu_result = w_src_a - w_src_b;
      OP_AND:  w_alu_result = w_src_a & w_src_b;
      OP_OR:   w_alu_result = w_src_a | w_src_b;
      OP_XOR:  w_alu_result = w_src_a ^ w_src_b;
      OP_SLT:  w_alu_result = XLEN'(w_lt_s);
      OP_SLTU: w_alu_result = XLEN'(w_lt_u);
      OP_SLL:  w_alu_result = w_src_a << w_shamt;
      OP_SRL:  w_alu_result = w_src_a >> w_shamt;
      OP_SRA:  w_alu_result = XLEN'($signed(w_src_a) >>> w_shamt);
      OP_MUL:  w_alu_result = w_mul_result;
      default: w_alu_result = '0;
    endcase
  end

  // Branch condition uses forwarded rs2, not the immediate-muxed SrcB
  always_comb begin
    w_cond = 1'b0;
    case (br_type_e)
      3'b000:  w_cond = (w_src_a == w_fwd_b);
      3'b001:  w_cond = (w_src_a != w_fwd_b);
      3'b100:  w_cond = ($signed(w_src_a) <  $signed(w_fwd_b));
      3'b101:  w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
      3'b110:  w_cond = (w_src_a <  w_fwd_b);
      3'b111:  w_cond = (w_src_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign pcsrc_e     = valid_e & ~flush_e & (jump_e | (branch_e & w_cond));
  assign pc_target_e = pc_e + imm_ext_e;

`ifdef EXEC_MUL_EN
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t      r_state;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic            w_mul_start;

  assign w_mul_start  = valid_e & ~flush_e & (alu_ctrl_e == OP_MUL);
  assign w_mul_result = r_acc;

  // Stall depends only on local state and E-slot inputs, never on stall_m
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_mul_start;
      S_BUSY:  w_stall = ~flush_e;
      default: w_stall = 1'b0;
    endcase
  end

  // Shift-add multiplier: one partial product per cycle, operands latched at start
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_mcand  <= w_src_a;
            r_mplier <= w_src_b;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(XLEN);
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush_e) begin
            r_state <= S_IDLE;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush_e || !stall_m) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_mul_result = '0;
  assign w_stall      = 1'b0;
`endif

  assign stall_e = w_stall;

  // EX/MEM register: reset > hold > bubble > capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 1'b0;
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
    end else if (!stall_m) begin
      result_src_m <= result_src_e;
      rd_m         <= rd_e;
      alu_result_m <= w_alu_result;
      write_data_m <= w_fwd_b;
      pc_plus4_m   <= pc_plus4_e;
      if (flush_e || !valid_e || w_stall) begin
        valid_m     <= 1'b0;
        reg_write_m <= 1'b0;
        mem_write_m <= 1'b0;
      end else begin
        valid_m     <= 1'b1;
        reg_write_m <= reg_write_e;
        mem_write_m <= mem_write_e;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Self-checking bench for execute_stage_pipe: directed cases plus randomized vectors
// against a behavioural model; multiplier cases run only when EXEC_MUL_EN is defined.
module tb_execute_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e, flush_e, stall_m;
  logic        reg_write_e, mem_write_e, result_src_e, alu_src_e;
  logic [3:0]  alu_ctrl_e;
  logic        branch_e, jump_e;
  logic [2:0]  br_type_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
  logic [4:0]  rd_e;
  logic        pcsrc_e, stall_e;
  logic [31:0] pc_target_e;
  logic        valid_m, reg_write_m, mem_write_m, result_src_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;

  int n_vec = 0;
  int n_err = 0;

  // Model of the EX/MEM register contents
  logic        m_valid, m_rw, m_mw, m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic        m_known;

  execute_stage_pipe #(.XLEN(32), .REG_AW(5), .ALUCTRL_W(4)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e), .stall_m(stall_m),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
    .alu_src_e(alu_src_e), .alu_ctrl_e(alu_ctrl_e), .branch_e(branch_e), .jump_e(jump_e),
    .br_type_e(br_type_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .rd1_e(rd1_e),
    .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .result_w(result_w), .rd_e(rd_e), .pcsrc_e(pcsrc_e), .pc_target_e(pc_target_e),
    .stall_e(stall_e), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return 32'(int'(a) >>> sh);
`ifdef EXEC_MUL_EN
      4'd10: return 32'(64'(a) * 64'(b));
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] rf);
    if (f == 2'b01) return result_w;
    if (f == 2'b10) return m_alu;
    return rf;
  endfunction

  function automatic logic br_ref(input logic [2:0] t, input logic [31:0] a,
                                  input logic [31:0] b);
    case (t)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return int'(a) < int'(b);
      3'b101: return int'(a) >= int'(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_known = 1;
  endtask

  // Inputs are already driven (called at negedge); check comb outputs, clock, check M
  task automatic cycle();
    logic [31:0] a, bf, b;
    logic pcs;
    #1;
    a   = pick(fwd_a_e, rd1_e);
    bf  = pick(fwd_b_e, rd2_e);
    b   = alu_src_e ? imm_ext_e : bf;
    pcs = valid_e && !flush_e && (jump_e || (branch_e && br_ref(br_type_e, a, bf)));
    check("pcsrc_e", 32'(pcsrc_e), 32'(pcs));
    check("pc_target_e", pc_target_e, pc_e + imm_ext_e);
    check("stall_e", 32'(stall_e), 32'd0);
    if (!stall_m) begin
      if (flush_e || !valid_e) begin
        m_valid = 0; m_rw = 0; m_mw = 0; m_known = 0;
      end else begin
        m_valid = 1; m_rw = reg_write_e; m_mw = mem_write_e; m_rs = result_src_e;
        m_rd = rd_e; m_alu = alu_ref(alu_ctrl_e, a, b); m_wd = bf; m_pc4 = pc_plus4_e;
        m_known = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("valid_m", 32'(valid_m), 32'(m_valid));
    check("reg_write_m", 32'(reg_write_m), 32'(m_rw));
    check("mem_write_m", 32'(mem_write_m), 32'(m_mw));
    if (m_known) begin
      check("result_src_m", 32'(result_src_m), 32'(m_rs));
      check("rd_m", 32'(rd_m), 32'(m_rd));
      check("alu_result_m", alu_result_m, m_alu);
      check("write_data_m", write_data_m, m_wd);
      check("pc_plus4_m", pc_plus4_m, m_pc4);
    end
  endtask

  task automatic idle_inputs();
    valid_e = 0; flush_e = 0; stall_m = 0; reg_write_e = 0; mem_write_e = 0;
    result_src_e = 0; alu_src_e = 0; alu_ctrl_e = 0; branch_e = 0; jump_e = 0;
    br_type_e = 0; fwd_a_e = 0; fwd_b_e = 0; rd1_e = 0; rd2_e = 0; imm_ext_e = 0;
    pc_e = 0; pc_plus4_e = 0; result_w = 0; rd_e = 0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    valid_e = 1; alu_ctrl_e = op; rd1_e = a; rd2_e = b; rd_e = rd; reg_write_e = 1;
    fwd_a_e = 0; fwd_b_e = 0; alu_src_e = 0; branch_e = 0; jump_e = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    model_reset();
    check("rst valid_m", 32'(valid_m), 32'd0);
    check("rst reg_write_m", 32'(reg_write_m), 32'd0);
    check("rst mem_write_m", 32'(mem_write_m), 32'd0);
    check("rst result_src_m", 32'(result_src_m), 32'd0);
    check("rst rd_m", 32'(rd_m), 32'd0);
    check("rst alu_result_m", alu_result_m, 32'd0);
    check("rst write_data_m", write_data_m, 32'd0);
    check("rst pc_plus4_m", pc_plus4_m, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    @(negedge clk);
    do_reset();

    // add x5 = 7 + 5
    alu_op(4'd0, 32'd7, 32'd5, 5'd5);
    cycle();
    check("add12", alu_result_m, 32'd12);
    check("add rd", 32'(rd_m), 32'd5);

    // forwarding from M wraps around
    alu_op(4'd0, 32'hFFFF_FFFF, 32'd0, 5'd6);
    cycle();
    alu_op(4'd0, 32'd0, 32'd1, 5'd7);
    fwd_a_e = 2'b10;
    cycle();
    check("fwd wrap", alu_result_m, 32'd0);

    // blt taken, bltu not taken on -1 vs 1
    alu_op(4'd1, 32'hFFFF_FFFF, 32'd1, 5'd0);
    reg_write_e = 0; branch_e = 1; br_type_e = 3'b100; pc_e = 32'h100; imm_ext_e = 32'h20;
    #1;
    check("blt pcsrc", 32'(pcsrc_e), 32'd1);
    check("blt target", pc_target_e, 32'h120);
    br_type_e = 3'b110;
    #1;
    check("bltu pcsrc", 32'(pcsrc_e), 32'd0);
    cycle();

    // downstream stall holds M for three cycles
    alu_op(4'd4, 32'h00FF_00FF, 32'h0F0F_0F0F, 5'd9);
    cycle();
    stall_m = 1;
    for (int i = 0; i < 3; i++) begin
      alu_op(4'd2, 32'(i + 100), 32'hFFFF, 5'(i + 1));
      cycle();
      check("hold alu", alu_result_m, 32'h0FF0_0FF0);
    end
    stall_m = 0;
    cycle();
    check("release alu", alu_result_m, 32'd102);

    // randomized vectors
    for (int n = 0; n < 400; n++) begin
      valid_e = ($urandom_range(0, 7) != 0);
      flush_e = ($urandom_range(0, 9) == 0);
      stall_m = ($urandom_range(0, 7) == 0);
      reg_write_e = 1'($urandom); mem_write_e = 1'($urandom); result_src_e = 1'($urandom);
      alu_src_e = 1'($urandom);
      alu_ctrl_e = 4'($urandom);
`ifdef EXEC_MUL_EN
      if (alu_ctrl_e == 4'd10) alu_ctrl_e = 4'd0;
`endif
      branch_e = 1'($urandom); jump_e = ($urandom_range(0, 5) == 0);
      br_type_e = 3'($urandom);
      fwd_a_e = 2'($urandom); fwd_b_e = 2'($urandom);
      if (!m_known && fwd_a_e == 2'b10) fwd_a_e = 2'b00;
      if (!m_known && fwd_b_e == 2'b10) fwd_b_e = 2'b00;
      rd1_e = $urandom; rd2_e = ($urandom_range(0, 3) == 0) ? rd1_e : $urandom;
      imm_ext_e = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      pc_e = $urandom; pc_plus4_e = $urandom; result_w = $urandom; rd_e = 5'($urandom);
      cycle();
    end

    // op 0xA without the multiplier must be a one-cycle zero
`ifndef EXEC_MUL_EN
    stall_m = 0; flush_e = 0;
    alu_op(4'd10, 32'd3, 32'd4, 5'd3);
    cycle();
    check("op A zero", alu_result_m, 32'd0);
`else
    begin
      int cnt;
      idle_inputs();
      alu_op(4'd10, 32'd3, 32'hFFFF_FFFF, 5'd8);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
        #1;
        if (!stall_e) break;
        cnt++;
        @(posedge clk);
        @(negedge clk);
        if (i == 0) check("mul bubble", 32'(valid_m), 32'd0);
      end
      check("mul stall cycles", 32'(cnt), 32'd33);
      @(posedge clk);
      @(negedge clk);
      check("mul result", alu_result_m, 32'hFFFF_FFFD);
      check("mul valid", 32'(valid_m), 32'd1);

      // flush during BUSY
      alu_op(4'd10, 32'd5, 32'd6, 5'd8);
      for (int i = 0; i < 11; i++) begin
        @(posedge clk);
        @(negedge clk);
      end
      flush_e = 1;
      #1;
      check("flush stall_e", 32'(stall_e), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("flush valid_m", 32'(valid_m), 32'd0);
      flush_e = 0;
      alu_op(4'd0, 32'd1, 32'd2, 5'd4);
      #1;
      check("post-flush stall", 32'(stall_e), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("post-flush add", alu_result_m, 32'd3);

      // reset mid-multiply
      alu_op(4'd10, 32'd5, 32'd6, 5'd8);
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        @(negedge clk);
      end
      valid_e = 0;
      do_reset();
      #1;
      check("rst stall_e", 32'(stall_e), 32'd0);
    end
`endif

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
